// File: rtl/line_window_3x3_if.sv
// line_window_3x3_if
//   Pixel-stream input and 3x3 window output of the line-window block.
//   master : pixel source / window consumer (drives in_*, observes window)
//   slave  : line_window_3x3 (observes in_*, drives window, win_*, frame_done)
//   in_valid/in_sof/in_pixel : raster-order pixel stream, one pixel per cycle
//   p1..p9                   : window, row-major, p1..p3 oldest line
//   win_valid                : window is new and complete this cycle
//   win_row/win_col          : frame coordinates of the window centre (p5)
//   frame_done               : pulse after the last pixel of a frame
interface line_window_3x3_if #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          in_valid;
  logic          in_sof;
  logic [7:0]    in_pixel;
  logic [7:0]    p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic          win_valid;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9,
    input  win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9,
    output win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/line_window_3x3.sv
// line_window_3x3
//   Builds a sliding 3x3 pixel window from a raster-order 8-bit stream using
//   two line buffers. No padding: windows are produced only where the centre
//   has a full neighbourhood, so a frame yields (IMG_W-2)*(IMG_H-2) windows.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset (line buffers are not cleared)
//   bus : line_window_3x3_if.slave (pixel stream in, window out)
module line_window_3x3 #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic              clk,
  input logic              rst,
  line_window_3x3_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  // line0 holds the older of the two stored lines, line1 the newer one
  logic [7:0]    line0_q [IMG_W];
  logic [7:0]    line1_q [IMG_W];
  logic [7:0]    l0, l1;

  logic [7:0]    p_q [9];
  logic          win_valid_q, frame_done_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;

  logic          accept, win_hit, last_hit;

  always_comb begin
    accept  = bus.in_valid;
    cur_col = col_q;
    cur_row = row_q;
    // sof forces the accepted pixel to (0,0) whatever the counters say
    if (bus.in_valid && bus.in_sof) begin
      cur_col = '0;
      cur_row = '0;
    end

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end

    l0 = line0_q[cur_col];
    l1 = line1_q[cur_col];

    // rows 0/1 of the current frame have been written before any window
    // reads them, so stale buffer contents never reach a valid window
    win_hit  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    last_hit = accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      line0_q[cur_col] <= l1;
      line1_q[cur_col] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
        // shift left one column; new right column comes from the buffers
        p_q[0] <= p_q[1];
        p_q[1] <= p_q[2];
        p_q[2] <= l0;
        p_q[3] <= p_q[4];
        p_q[4] <= p_q[5];
        p_q[5] <= l1;
        p_q[6] <= p_q[7];
        p_q[7] <= p_q[8];
        p_q[8] <= bus.in_pixel;
        win_valid_q  <= win_hit;
        frame_done_q <= last_hit;
        if (win_hit) begin
          win_row_q <= cur_row - RW'(1);
          win_col_q <= cur_col - CW'(1);
        end
      end
    end
  end

  assign bus.p1         = p_q[0];
  assign bus.p2         = p_q[1];
  assign bus.p3         = p_q[2];
  assign bus.p4         = p_q[3];
  assign bus.p5         = p_q[4];
  assign bus.p6         = p_q[5];
  assign bus.p7         = p_q[6];
  assign bus.p8         = p_q[7];
  assign bus.p9         = p_q[8];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
endmodule

// File: tb/tb_line_window_3x3.sv
// tb_line_window_3x3
//   Directed bench: a 4x4 instance (a) for stream, gap, sof and reset
//   scenarios, and a 5x3 instance (b) for the column-boundary scenario.
module tb_line_window_3x3;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  line_window_3x3_if #(.IMG_W(4), .IMG_H(4)) a ();
  line_window_3x3_if #(.IMG_W(5), .IMG_H(3)) b ();

  line_window_3x3 #(.IMG_W(4), .IMG_H(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
  line_window_3x3 #(.IMG_W(5), .IMG_H(3)) dut_b (.clk(clk), .rst(rst), .bus(b));

  wire [71:0] win_a = {a.p1, a.p2, a.p3, a.p4, a.p5, a.p6, a.p7, a.p8, a.p9};
  wire [71:0] win_b = {b.p1, b.p2, b.p3, b.p4, b.p5, b.p6, b.p7, b.p8, b.p9};

  // expected window for newest pixel (r,c) of a frame with value base+w*r+c
  function automatic logic [71:0] win_exp(int base, int w, int r, int c);
    logic [71:0] res;
    res = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        res = {res[63:0], 8'(base + w * (r - 2 + dr) + (c - 2 + dc))};
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a.in_valid = 1'b1; a.in_sof = 1'b0; a.in_pixel = 8'hAA;
    b.in_valid = 1'b1; b.in_sof = 1'b0; b.in_pixel = 8'h55;
    tick();
    rst = 1'b0;
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
    total_cnt++; if (a.win_valid !== 1'b0) $display("FAIL reset_win_valid got %0b exp 0", a.win_valid); else pass_cnt++;
    total_cnt++; if (a.frame_done !== 1'b0) $display("FAIL reset_frame_done got %0b exp 0", a.frame_done); else pass_cnt++;
    total_cnt++; if (win_a !== 72'h0) $display("FAIL reset_window got %h exp 0", win_a); else pass_cnt++;
    total_cnt++; if (a.win_row !== 2'd0) $display("FAIL reset_win_row got %0d exp 0", a.win_row); else pass_cnt++;
    total_cnt++; if (a.win_col !== 2'd0) $display("FAIL reset_win_col got %0d exp 0", a.win_col); else pass_cnt++;
    total_cnt++; if (b.win_valid !== 1'b0) $display("FAIL reset_b_win_valid got %0b exp 0", b.win_valid); else pass_cnt++;
    total_cnt++; if (win_b !== 72'h0) $display("FAIL reset_b_window got %h exp 0", win_b); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [7:0] p9_list [4];
    int nwin;
    logic exp_v;
    p9_list = '{8'd10, 8'd11, 8'd14, 8'd15};
    nwin = 0;
    for (int i = 0; i < 16; i++) begin
      a.in_valid = 1'b1; a.in_sof = (i == 0); a.in_pixel = 8'(i);
      tick();
      exp_v = (i / 4 >= 2) && (i % 4 >= 2);
      total_cnt++; if (a.win_valid !== exp_v) $display("FAIL stream_win_valid i=%0d got %0b exp %0b", i, a.win_valid, exp_v); else pass_cnt++;
      total_cnt++; if (a.frame_done !== (i == 15)) $display("FAIL stream_frame_done i=%0d got %0b exp %0b", i, a.frame_done, (i == 15)); else pass_cnt++;
      if (i == 10) begin
        total_cnt++; if (win_a !== 72'h000102_040506_08090a) $display("FAIL stream_first_window got %h exp 00010204050608090a", win_a); else pass_cnt++;
      end
      if (exp_v) begin
        nwin++;
        total_cnt++; if (win_a !== win_exp(0, 4, i / 4, i % 4)) $display("FAIL stream_window i=%0d got %h exp %h", i, win_a, win_exp(0, 4, i / 4, i % 4)); else pass_cnt++;
        total_cnt++; if (a.p9 !== p9_list[nwin-1]) $display("FAIL stream_p9 i=%0d got %0d exp %0d", i, a.p9, p9_list[nwin-1]); else pass_cnt++;
        total_cnt++; if (a.win_row !== 2'(i / 4 - 1)) $display("FAIL stream_win_row i=%0d got %0d exp %0d", i, a.win_row, i / 4 - 1); else pass_cnt++;
        total_cnt++; if (a.win_col !== 2'(i % 4 - 1)) $display("FAIL stream_win_col i=%0d got %0d exp %0d", i, a.win_col, i % 4 - 1); else pass_cnt++;
      end
    end
    total_cnt++; if (nwin != 4) $display("FAIL stream_window_count got %0d exp 4", nwin); else pass_cnt++;
    a.in_valid = 1'b0; a.in_sof = 1'b0;
    tick();
    total_cnt++; if (a.win_valid !== 1'b0) $display("FAIL idle_win_valid got %0b exp 0", a.win_valid); else pass_cnt++;
    total_cnt++; if (a.frame_done !== 1'b0) $display("FAIL idle_frame_done got %0b exp 0", a.frame_done); else pass_cnt++;
    total_cnt++; if (win_a !== win_exp(0, 4, 3, 3)) $display("FAIL idle_window_hold got %h exp %h", win_a, win_exp(0, 4, 3, 3)); else pass_cnt++;
  endtask

  task automatic test_gaps();
    int nwin;
    logic exp_v;
    nwin = 0;
    for (int i = 0; i < 16; i++) begin
      a.in_valid = 1'b1; a.in_sof = (i == 0); a.in_pixel = 8'(i);
      tick();
      exp_v = (i / 4 >= 2) && (i % 4 >= 2);
      total_cnt++; if (a.win_valid !== exp_v) $display("FAIL gap_win_valid i=%0d got %0b exp %0b", i, a.win_valid, exp_v); else pass_cnt++;
      total_cnt++; if (a.frame_done !== (i == 15)) $display("FAIL gap_frame_done i=%0d got %0b exp %0b", i, a.frame_done, (i == 15)); else pass_cnt++;
      if (exp_v) begin
        nwin++;
        total_cnt++; if (win_a !== win_exp(0, 4, i / 4, i % 4)) $display("FAIL gap_window i=%0d got %h exp %h", i, win_a, win_exp(0, 4, i / 4, i % 4)); else pass_cnt++;
      end
      a.in_valid = 1'b0; a.in_sof = 1'b0; a.in_pixel = 8'hEE;
      tick();
      total_cnt++; if (a.win_valid !== 1'b0) $display("FAIL gap_idle_win_valid i=%0d got %0b exp 0", i, a.win_valid); else pass_cnt++;
      total_cnt++; if (a.frame_done !== 1'b0) $display("FAIL gap_idle_frame_done i=%0d got %0b exp 0", i, a.frame_done); else pass_cnt++;
      if (exp_v) begin
        total_cnt++; if (win_a !== win_exp(0, 4, i / 4, i % 4)) $display("FAIL gap_hold_window i=%0d got %h exp %h", i, win_a, win_exp(0, 4, i / 4, i % 4)); else pass_cnt++;
        total_cnt++; if ({a.win_row, a.win_col} !== {2'(i / 4 - 1), 2'(i % 4 - 1)}) $display("FAIL gap_hold_coords i=%0d got %0d,%0d exp %0d,%0d", i, a.win_row, a.win_col, i / 4 - 1, i % 4 - 1); else pass_cnt++;
      end
    end
    total_cnt++; if (nwin != 4) $display("FAIL gap_window_count got %0d exp 4", nwin); else pass_cnt++;
  endtask

  task automatic test_sof_mid();
    int first_k;
    logic exp_v;
    first_k = -1;
    for (int i = 0; i < 6; i++) begin
      a.in_valid = 1'b1; a.in_sof = 1'b0; a.in_pixel = 8'(100 + i);
      tick();
      total_cnt++; if (a.win_valid !== 1'b0) $display("FAIL sof_pre_win_valid i=%0d got %0b exp 0", i, a.win_valid); else pass_cnt++;
      total_cnt++; if (a.frame_done !== 1'b0) $display("FAIL sof_pre_frame_done i=%0d got %0b exp 0", i, a.frame_done); else pass_cnt++;
    end
    for (int k = 0; k < 16; k++) begin
      a.in_valid = 1'b1; a.in_sof = (k == 0); a.in_pixel = 8'(20 + k);
      tick();
      exp_v = (k / 4 >= 2) && (k % 4 >= 2);
      if (a.win_valid === 1'b1 && first_k < 0) first_k = k;
      total_cnt++; if (a.win_valid !== exp_v) $display("FAIL sof_win_valid k=%0d got %0b exp %0b", k, a.win_valid, exp_v); else pass_cnt++;
      total_cnt++; if (a.frame_done !== (k == 15)) $display("FAIL sof_frame_done k=%0d got %0b exp %0b", k, a.frame_done, (k == 15)); else pass_cnt++;
      if (exp_v) begin
        total_cnt++; if (win_a !== win_exp(20, 4, k / 4, k % 4)) $display("FAIL sof_window k=%0d got %h exp %h", k, win_a, win_exp(20, 4, k / 4, k % 4)); else pass_cnt++;
      end
    end
    a.in_valid = 1'b0; a.in_sof = 1'b0;
    total_cnt++; if (first_k != 10) $display("FAIL sof_first_window_index got %0d exp 10", first_k); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic exp_v;
    for (int i = 0; i < 10; i++) begin
      a.in_valid = 1'b1; a.in_sof = (i == 0); a.in_pixel = 8'(i);
      tick();
    end
    rst = 1'b1; a.in_valid = 1'b1; a.in_sof = 1'b0; a.in_pixel = 8'hFF;
    tick();
    rst = 1'b0; a.in_valid = 1'b0;
    total_cnt++; if (a.win_valid !== 1'b0) $display("FAIL rstmid_win_valid got %0b exp 0", a.win_valid); else pass_cnt++;
    total_cnt++; if (a.frame_done !== 1'b0) $display("FAIL rstmid_frame_done got %0b exp 0", a.frame_done); else pass_cnt++;
    total_cnt++; if (win_a !== 72'h0) $display("FAIL rstmid_window got %h exp 0", win_a); else pass_cnt++;
    total_cnt++; if ({a.win_row, a.win_col} !== 4'h0) $display("FAIL rstmid_coords got %0d,%0d exp 0,0", a.win_row, a.win_col); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      a.in_valid = 1'b1; a.in_sof = 1'b0; a.in_pixel = 8'(50 + k);
      tick();
      exp_v = (k / 4 >= 2) && (k % 4 >= 2);
      total_cnt++; if (a.win_valid !== exp_v) $display("FAIL rstmid_win_valid k=%0d got %0b exp %0b", k, a.win_valid, exp_v); else pass_cnt++;
      total_cnt++; if (a.frame_done !== (k == 15)) $display("FAIL rstmid_frame_done k=%0d got %0b exp %0b", k, a.frame_done, (k == 15)); else pass_cnt++;
      if (exp_v) begin
        total_cnt++; if (win_a !== win_exp(50, 4, k / 4, k % 4)) $display("FAIL rstmid_window k=%0d got %h exp %h", k, win_a, win_exp(50, 4, k / 4, k % 4)); else pass_cnt++;
      end
    end
    a.in_valid = 1'b0;
  endtask

  task automatic test_w5();
    int nwin;
    logic exp_v;
    nwin = 0;
    for (int i = 0; i < 15; i++) begin
      b.in_valid = 1'b1; b.in_sof = (i == 0); b.in_pixel = 8'(i);
      tick();
      exp_v = (i / 5 == 2) && (i % 5 >= 2);
      total_cnt++; if (b.win_valid !== exp_v) $display("FAIL w5_win_valid i=%0d got %0b exp %0b", i, b.win_valid, exp_v); else pass_cnt++;
      total_cnt++; if (b.frame_done !== (i == 14)) $display("FAIL w5_frame_done i=%0d got %0b exp %0b", i, b.frame_done, (i == 14)); else pass_cnt++;
      if (exp_v) begin
        nwin++;
        total_cnt++; if (b.win_col !== 3'(i % 5 - 1)) $display("FAIL w5_win_col i=%0d got %0d exp %0d", i, b.win_col, i % 5 - 1); else pass_cnt++;
        total_cnt++; if (b.win_row !== 2'd1) $display("FAIL w5_win_row i=%0d got %0d exp 1", i, b.win_row); else pass_cnt++;
        total_cnt++; if (win_b !== win_exp(0, 5, i / 5, i % 5)) $display("FAIL w5_window i=%0d got %h exp %h", i, win_b, win_exp(0, 5, i / 5, i % 5)); else pass_cnt++;
      end
    end
    b.in_valid = 1'b0; b.in_sof = 1'b0;
    total_cnt++; if (nwin != 3) $display("FAIL w5_window_count got %0d exp 3", nwin); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    a.in_valid = 1'b0; a.in_sof = 1'b0; a.in_pixel = 8'h0;
    b.in_valid = 1'b0; b.in_sof = 1'b0; b.in_pixel = 8'h0;
    tick();
    test_reset();
    test_stream();
    test_gaps();
    test_sof_mid();
    test_reset_mid();
    test_w5();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning pixels per line (minimum 3).
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning lines per frame (minimum 3).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: in_pixel is accepted on this cycle.
REQ-006 The block SHALL have the port in_sof, input, 1 bit: qualified by in_valid; marks the accepted pixel as frame position (0,0).
REQ-007 The block SHALL have the port in_pixel, input, 8 bits: unsigned raster-order pixel.
REQ-008 The block SHALL have the ports p1 through p9, output, 8 bits each: the 3x3 window in row-major order. p1..p3 are the oldest line, p7..p9 the newest line, and p1/p4/p7 the leftmost column.
REQ-009 The block SHALL have the port win_valid, output, 1 bit: the window is new and complete on this cycle.
REQ-010 The block SHALL have the ports win_row and win_col, outputs, each clog2(IMG_H) and clog2(IMG_W) bits: the frame coordinates of the window centre (p5).
REQ-011 The block SHALL have the port frame_done, output, 1 bit: a one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 The block SHALL hold two line buffers of IMG_W x 8 bits, storing the previous two lines, indexed by column.
REQ-013 On every accepted pixel at column c, the block SHALL do two things: read both buffers at c, and write line1[c] to line0[c] and in_pixel to line1[c].
REQ-014 On every accepted pixel, the window SHALL shift left one column, and the new right column SHALL become {line0[c], line1[c], in_pixel} into {p3, p6, p9}.
REQ-015 The block SHALL keep counters col (0..IMG_W-1) and row (0..IMG_H-1) for the accepted pixel, as follows:
- col SHALL increment per accepted pixel.
- At IMG_W-1, col SHALL wrap to 0 and row SHALL increment.
- At (IMG_H-1, IMG_W-1), both SHALL wrap to 0.
REQ-016 If in_valid and in_sof are both high, the accepted pixel SHALL be treated as (0,0), regardless of the counter state. The counters SHALL continue from (0,1), and line buffer contents SHALL NOT be cleared.
REQ-017 win_valid SHALL be asserted exactly one cycle after the acceptance of a pixel at (row >= 2, col >= 2).
- win_row SHALL equal row-1 and win_col SHALL equal col-1 of that pixel.
- p9 SHALL equal that pixel.
REQ-018 No window SHALL straddle a line boundary. There is no padding: each frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-019 When in_valid is low, no state SHALL change. win_valid and frame_done SHALL be low on the following cycle, and p1..p9, win_row and win_col SHALL hold their values.
REQ-020 frame_done SHALL pulse one cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted, coincident with the final win_valid.
REQ-021 If in_sof arrives mid-frame, no frame_done SHALL be generated for the abandoned frame.
REQ-022 There SHALL be no backpressure: the block accepts one pixel per cycle, and the consumer must take each window on the win_valid cycle.
REQ-023 The output registers SHALL connect directly to a combinational 3x3 kernel (p1..p9, 8-bit). The kernel output SHALL be qualified by win_valid.

Reset
REQ-024 When rst is high at a clock edge, the block SHALL clear the following, overriding in_valid on that cycle:
- col and row to 0;
- p1..p9, win_row and win_col to 0;
- win_valid and frame_done to 0.
REQ-025 Reset SHALL NOT be required to clear the line buffers; stale contents SHALL never reach a valid window.
REQ-026 After reset deasserts, the first accepted pixel SHALL be (0,0), whether or not in_sof is asserted.

Verification
REQ-027 With IMG_W=4, IMG_H=4 and pixel = 4r+c streamed continuously, the bench SHALL check:
- First win_valid one cycle after pixel 10.
- Window p1..p9 = 0,1,2,4,5,6,8,9,10, with win_row=1 and win_col=1.
REQ-028 For the same stream, the bench SHALL check:
- Exactly 4 windows, with p9 = 10, 11, 14, 15.
- frame_done high only on the cycle with p9=15.
REQ-029 For the same stream with in_valid low on every other cycle, the bench SHALL check:
- Identical window sequence.
- win_valid never on consecutive cycles.
- Outputs held during gaps.
REQ-030 With in_sof asserted at pixel index 6 of a frame, then a clean 16-pixel frame, the bench SHALL check:
- The first window is one cycle after the 11th pixel following the sof.
- There is no frame_done for the abandoned frame.
REQ-031 With rst asserted for one cycle after pixel 9, then a fresh frame, the bench SHALL check:
- All outputs are 0 the cycle after reset.
- The next window is the correct first window of the new frame.
REQ-032 With IMG_W=5 and IMG_H=3, the bench SHALL check that exactly 3 windows are produced with win_col = 1, 2, 3, and none at columns 0 or 4.
